lpddr2_arbiter: RTL and testbench
=================================

LPDDR2_ARBITER -- requirements
Module: lpddr2_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, meaning LPDDR2 word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning maximum cycles waited for read data before aborting.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on posedge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports if_req in 1, if_addr in ADDR_W, if_rdata out 32, if_ack out 1: instruction-fetch read port.
REQ-006 SHALL have ports d_rreq in 1, d_wreq in 1, d_addr in ADDR_W, d_wdata in 32, d_rdata out 32, d_ack out 1: load/store port.
REQ-007 SHALL have ports lpddr2_address out ADDR_W, lpddr2_write_data out 32, lpddr2_rreq out 1, lpddr2_wreq out 1 toward the LPDDR2 controller.
REQ-008 SHALL have ports lpddr2_read_data in 32, lpddr2_waitrequest in 1, lpddr2_rvalid in 1 from the LPDDR2 controller.
REQ-009 SHALL have port err out 1: sticky error flag (timeout or protocol violation).

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT_R, RESP.
REQ-011 SHALL treat requests as levels: held by the requester until its ack, dropped in the cycle after ack.
REQ-012 SHALL, in IDLE with any request pending, grant one requester, latch its address/wdata/direction, and go to ISSUE next cycle.
REQ-013 SHALL arbitrate round-robin: when both ports request in the same IDLE cycle, grant the port not granted last; after reset the data port wins first.
REQ-014 SHALL treat d_rreq and d_wreq both high as a write and set err.
REQ-015 SHALL, in ISSUE, drive lpddr2_rreq or lpddr2_wreq high with latched address/data, holding them stable while lpddr2_waitrequest=1.
REQ-016 SHALL, when lpddr2_waitrequest=0 in ISSUE, go to WAIT_R for a read or RESP for a write.
REQ-017 SHALL, in WAIT_R, capture lpddr2_read_data into the granted port's rdata register when lpddr2_rvalid=1 and go to RESP.
REQ-018 SHALL count WAIT_R cycles; after TIMEOUT cycles without rvalid, load rdata with 32'hDEADBEEF, set err, and go to RESP.
REQ-019 SHALL ignore lpddr2_rvalid outside WAIT_R.
REQ-020 SHALL, in RESP, pulse exactly one cycle of the granted port's ack (if_ack or d_ack), ignore all requests, and return to IDLE.
REQ-021 SHALL hold if_rdata/d_rdata stable until that port's next read completes.
REQ-022 SHALL give minimum latency: write ack 3 cycles after request, read ack 4 cycles after request (zero waitrequest, rvalid on first WAIT_R cycle).
REQ-023 SHALL never assert lpddr2_rreq and lpddr2_wreq together, nor either outside ISSUE.
REQ-024 SHALL not let a new request preempt a transaction in progress.

Reset
REQ-025 SHALL, while rst=0, force state IDLE, all acks/req outputs 0, rdata registers 0, lpddr2_address/write_data 0, err 0, timeout counter 0, last-grant = fetch.
REQ-026 SHALL abort any in-flight transaction on reset assertion without issuing an ack; post-reset rvalid is ignored.
REQ-027 SHALL clear err only by reset.

Verification
REQ-028 SHALL test: if_req=1, if_addr=0x10, waitrequest=0, rvalid with 0x12345678 one cycle after ISSUE -> if_ack single pulse, if_rdata=0x12345678, 4-cycle latency.
REQ-029 SHALL test: if_req and d_wreq raised together, repeated twice -> data write first, fetch read second, then fetch granted first on third tie.
REQ-030 SHALL test: d_wreq, d_addr=0x20, d_wdata=0xCAFEF00D, waitrequest high 5 cycles -> lpddr2_wreq/address/data stable 6 cycles, d_ack pulse after acceptance.
REQ-031 SHALL test: read with rvalid never asserted -> d_ack after TIMEOUT WAIT_R cycles, d_rdata=0xDEADBEEF, err=1 and sticky.
REQ-032 SHALL test: rst driven low during WAIT_R, then released and late rvalid applied -> no ack, outputs at reset values, next request served normally.

Source files
------------

// File: rtl/lpddr2_arbiter.sv
// lpddr2_arbiter
//   Two-port arbiter in front of a single LPDDR2 controller port. The
//   instruction-fetch port (read only) and the load/store port share the
//   controller. Arbitration is round-robin, and one transaction is in flight
//   at a time.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   if_req, if_addr          fetch read request (level) and word address
//   if_rdata, if_ack         fetch read data register and one-cycle ack
//   d_rreq, d_wreq, d_addr   load/store read/write request (level), address
//   d_wdata                  store data
//   d_rdata, d_ack           load data register and one-cycle ack
//   lpddr2_*                 command/data toward and from the controller
//   err                      sticky error (read timeout or rreq+wreq together)
//   state_dbg                current FSM state (IDLE=0 ISSUE=1 WAIT_R=2 RESP=3)
//
// Handshakes
//   Requester side: a request is a level. It is held until the port's ack
//   pulse and dropped in the cycle after the ack. The ack lasts exactly one
//   cycle.
//   Controller side: lpddr2_rreq or lpddr2_wreq is the valid signal, and
//   !lpddr2_waitrequest is the ready signal. A command transfers on a rising
//   edge where valid=1 and waitrequest=0. Address and data stay stable while
//   waitrequest=1. lpddr2_rvalid qualifies lpddr2_read_data and is sampled
//   only while the arbiter waits for read data.

module lpddr2_arbiter #(
    parameter int ADDR_W  = 27,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              d_rreq,
    input  logic              d_wreq,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] lpddr2_address,
    output logic [31:0]       lpddr2_write_data,
    output logic              lpddr2_rreq,
    output logic              lpddr2_wreq,
    input  logic [31:0]       lpddr2_read_data,
    input  logic              lpddr2_waitrequest,
    input  logic              lpddr2_rvalid,
    output logic              err,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic               grant_d;    // transaction in flight belongs to the data port
    logic               is_write;   // transaction in flight is a write
    logic               last_d;     // most recent grant went to the data port
    logic [CNT_W-1:0]   wait_cnt;   // WAIT_R cycles spent so far without rvalid

    logic d_req;
    logic any_req;
    logic pick_d;
    logic timeout_hit;

    assign d_req   = d_rreq | d_wreq;
    assign any_req = if_req | d_req;
    // On a tie the port that did not win last time gets the grant.
    assign pick_d  = d_req & (~if_req | ~last_d);
    // This is the TIMEOUT-th WAIT_R cycle, and still no data has come back.
    assign timeout_hit = (state == WAIT_R) && !lpddr2_rvalid &&
                         (wait_cnt == CNT_W'(TIMEOUT - 1));

    assign state_dbg = state;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   if (!lpddr2_waitrequest) state_nxt = is_write ? RESP : WAIT_R;
            WAIT_R:  if (lpddr2_rvalid || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        lpddr2_rreq = 1'b0;
        lpddr2_wreq = 1'b0;
        if_ack      = 1'b0;
        d_ack       = 1'b0;
        case (state)
            ISSUE: begin
                lpddr2_rreq = ~is_write;
                lpddr2_wreq = is_write;
            end
            RESP: begin
                if_ack = ~grant_d;
                d_ack  = grant_d;
            end
            default: ;
        endcase
    end

    // Datapath: grant latch, read-data capture, timeout counter, error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_d           <= 1'b0;
            is_write          <= 1'b0;
            last_d            <= 1'b0;
            lpddr2_address    <= '0;
            lpddr2_write_data <= '0;
            if_rdata          <= '0;
            d_rdata           <= '0;
            wait_cnt          <= '0;
            err               <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_d        <= pick_d;
                last_d         <= pick_d;
                // When rreq and wreq are both high, the request is a write.
                is_write       <= pick_d & d_wreq;
                lpddr2_address <= pick_d ? d_addr : if_addr;
                if (pick_d && d_wreq) begin
                    lpddr2_write_data <= d_wdata;
                end
                if (pick_d && d_rreq && d_wreq) begin
                    err <= 1'b1;
                end
            end

            if (state == WAIT_R) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (state == WAIT_R) begin
                if (lpddr2_rvalid) begin
                    if (grant_d) d_rdata  <= lpddr2_read_data;
                    else         if_rdata <= lpddr2_read_data;
                end else if (timeout_hit) begin
                    if (grant_d) d_rdata  <= 32'hDEADBEEF;
                    else         if_rdata <= 32'hDEADBEEF;
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lpddr2_arbiter.sv
// tb_lpddr2_arbiter
//   Bench for lpddr2_arbiter. Each test pushes the acks it expects (port and
//   rdata) to exp_q and the controller commands it expects to bus_q. A
//   responder plays the LPDDR2 controller. It checks every issue cycle
//   against bus_q. A monitor pops exp_q on every ack.

module tb_lpddr2_arbiter;

    localparam int ADDR_W = 27;
    localparam int TMO    = 20;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;
    logic              d_rreq;
    logic              d_wreq;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_ack;
    logic [ADDR_W-1:0] lpddr2_address;
    logic [31:0]       lpddr2_write_data;
    logic              lpddr2_rreq;
    logic              lpddr2_wreq;
    logic [31:0]       lpddr2_read_data;
    logic              lpddr2_waitrequest;
    logic              lpddr2_rvalid;
    logic              err;
    logic [1:0]        state_dbg;

    lpddr2_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
        .clk                (clk),
        .rst                (rst),
        .if_req             (if_req),
        .if_addr            (if_addr),
        .if_rdata           (if_rdata),
        .if_ack             (if_ack),
        .d_rreq             (d_rreq),
        .d_wreq             (d_wreq),
        .d_addr             (d_addr),
        .d_wdata            (d_wdata),
        .d_rdata            (d_rdata),
        .d_ack              (d_ack),
        .lpddr2_address     (lpddr2_address),
        .lpddr2_write_data  (lpddr2_write_data),
        .lpddr2_rreq        (lpddr2_rreq),
        .lpddr2_wreq        (lpddr2_wreq),
        .lpddr2_read_data   (lpddr2_read_data),
        .lpddr2_waitrequest (lpddr2_waitrequest),
        .lpddr2_rvalid      (lpddr2_rvalid),
        .err                (err),
        .state_dbg          (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [32:0] exp_q[$];   // {is_data_port, rdata of that port at ack}
    logic [64:0] bus_q[$];   // {is_write, addr(32), wdata(32)}
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mdl_if_rdata = '0;
    logic [31:0] mdl_d_rdata  = '0;

    // Responder knobs
    int          ws       = 0;   // waitrequest cycles before acceptance
    int          rv_delay = 0;   // WAIT_R cycles before rvalid
    logic        rv_en    = 1'b1;
    logic [31:0] rv_data  = '0;
    logic        force_rv = 1'b0;
    int          bus_cycles = 0;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- controller responder ----------------
    initial begin : responder
        int          issue_cnt;
        int          rd_cnt;
        logic        pend;
        logic [64:0] cur_bus;
        issue_cnt = 0;
        rd_cnt    = 0;
        pend      = 1'b0;
        cur_bus   = '0;
        lpddr2_waitrequest = 1'b0;
        lpddr2_rvalid      = 1'b0;
        lpddr2_read_data   = '0;
        forever begin
            @(negedge clk);
            lpddr2_rvalid = 1'b0;
            if (!rst) begin
                issue_cnt = 0;
                pend      = 1'b0;
                lpddr2_waitrequest = 1'b0;
            end else begin
                if (force_rv) begin
                    lpddr2_rvalid    = 1'b1;
                    lpddr2_read_data = rv_data;
                    force_rv         = 1'b0;
                end else if (pend) begin
                    if (rv_en && rd_cnt == rv_delay) begin
                        lpddr2_rvalid    = 1'b1;
                        lpddr2_read_data = rv_data;
                        pend             = 1'b0;
                    end else begin
                        rd_cnt++;
                    end
                end
                if (lpddr2_rreq || lpddr2_wreq) begin
                    if (issue_cnt == 0) begin
                        if (bus_q.size() == 0) begin
                            check("bus_unexpected", 1, 0);
                            cur_bus = {lpddr2_wreq, 5'b0, lpddr2_address, lpddr2_write_data};
                        end else begin
                            cur_bus = bus_q.pop_front();
                        end
                    end
                    check("bus_excl", lpddr2_rreq & lpddr2_wreq, 0);
                    check("bus_dir", lpddr2_wreq, cur_bus[64]);
                    check("bus_addr", {5'b0, lpddr2_address}, cur_bus[63:32]);
                    if (lpddr2_wreq) check("bus_wdata", lpddr2_write_data, cur_bus[31:0]);
                    lpddr2_waitrequest = (issue_cnt < ws);
                    if (issue_cnt >= ws && lpddr2_rreq) begin
                        pend   = 1'b1;
                        rd_cnt = 0;
                    end
                    issue_cnt++;
                    bus_cycles++;
                end else begin
                    issue_cnt = 0;
                    lpddr2_waitrequest = 1'b0;
                end
            end
        end
    end

    // ---------------- ack monitor ----------------
    initial begin : ack_monitor
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (if_ack || d_ack) begin
                check("ack_excl", if_ack & d_ack, 0);
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_rec", {d_ack, d_ack ? d_rdata : if_rdata}, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Call right after a rising edge. lat counts falling edges, the request
    // cycle included, until the ack is seen.
    task automatic if_read(input logic [ADDR_W-1:0] a, output int lat);
        if_req  = 1'b1;
        if_addr = a;
        lat     = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            lat++;
            if (if_ack) break;
        end
        if (!if_ack) check("if_ack_wait", 0, 1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic d_access(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                            input logic [31:0] wd, output int lat);
        d_rreq  = rd;
        d_wreq  = wr;
        d_addr  = a;
        d_wdata = wd;
        lat     = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            lat++;
            if (d_ack) break;
        end
        if (!d_ack) check("d_ack_wait", 0, 1);
        @(posedge clk);
        #1;
        d_rreq = 1'b0;
        d_wreq = 1'b0;
    endtask

    // Expectation helpers
    task automatic exp_if_read(input logic [ADDR_W-1:0] a, input logic [31:0] data);
        mdl_if_rdata = data;
        bus_q.push_back({1'b0, 5'b0, a, 32'h0});
        exp_q.push_back({1'b0, data});
    endtask

    task automatic exp_d_write(input logic [ADDR_W-1:0] a, input logic [31:0] wd);
        bus_q.push_back({1'b1, 5'b0, a, wd});
        exp_q.push_back({1'b1, mdl_d_rdata});
    endtask

    task automatic exp_d_read(input logic [ADDR_W-1:0] a, input logic [31:0] data);
        mdl_d_rdata = data;
        bus_q.push_back({1'b0, 5'b0, a, 32'h0});
        exp_q.push_back({1'b1, data});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_ack"}, if_ack, 0);
        check({tag, "_d_ack"}, d_ack, 0);
        check({tag, "_rreq"}, lpddr2_rreq, 0);
        check({tag, "_wreq"}, lpddr2_wreq, 0);
        check({tag, "_if_rdata"}, if_rdata, 0);
        check({tag, "_d_rdata"}, d_rdata, 0);
        check({tag, "_addr"}, lpddr2_address, 0);
        check({tag, "_wdata"}, lpddr2_write_data, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int lat_i;
        int lat_d;
        int cyc0;
        rst     = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_rreq  = 1'b0;
        d_wreq  = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Ties: data wins after reset, then the grant alternates.
        ws = 0; rv_delay = 0; rv_en = 1'b1;
        for (int t = 0; t < 2; t++) begin
            rv_data = 32'hF000_0001 + 32'(t);
            exp_d_write(ADDR_W'(32'h100 + t), 32'h1111_1111 * (t + 1));
            exp_if_read(ADDR_W'(32'h200 + t), rv_data);
            fork
                d_access(1'b0, 1'b1, ADDR_W'(32'h100 + t), 32'h1111_1111 * (t + 1), lat_d);
                if_read(ADDR_W'(32'h200 + t), lat_i);
            join
            check("tie_d_lat", lat_d, 3);
            check("tie_if_lat", lat_i, 7);
        end
        exp_d_write(ADDR_W'(32'h300), 32'h3333_3333);
        d_access(1'b0, 1'b1, ADDR_W'(32'h300), 32'h3333_3333, lat_d);
        check("solo_w_lat", lat_d, 3);
        rv_data = 32'hF000_0003;
        exp_if_read(ADDR_W'(32'h202), rv_data);
        exp_d_write(ADDR_W'(32'h102), 32'h4444_4444);
        fork
            d_access(1'b0, 1'b1, ADDR_W'(32'h102), 32'h4444_4444, lat_d);
            if_read(ADDR_W'(32'h202), lat_i);
        join
        check("tie3_if_lat", lat_i, 4);
        check("tie3_d_lat", lat_d, 7);

        // Minimum-latency fetch read.
        rv_data = 32'h1234_5678;
        exp_if_read(ADDR_W'(32'h10), rv_data);
        if_read(ADDR_W'(32'h10), lat_i);
        check("if_rd_lat", lat_i, 4);
        check("if_rdata", if_rdata, 32'h1234_5678);

        // Write held off by waitrequest for 5 cycles.
        ws = 5;
        cyc0 = bus_cycles;
        exp_d_write(ADDR_W'(32'h20), 32'hCAFE_F00D);
        d_access(1'b0, 1'b1, ADDR_W'(32'h20), 32'hCAFE_F00D, lat_d);
        check("ws_bus_cycles", bus_cycles - cyc0, 6);
        check("ws_w_lat", lat_d, 8);
        check("if_rdata_hold", if_rdata, mdl_if_rdata);
        ws = 0;

        // Read timeout.
        check("err_before_tmo", err, 0);
        rv_en = 1'b0;
        exp_d_read(ADDR_W'(32'h30), 32'hDEAD_BEEF);
        d_access(1'b1, 1'b0, ADDR_W'(32'h30), 32'h0, lat_d);
        check("tmo_lat", lat_d, 3 + TMO);
        check("tmo_d_rdata", d_rdata, 32'hDEAD_BEEF);
        check("tmo_err", err, 1);
        rv_en = 1'b1;
        rv_data = 32'h0BAD_CAFE;
        exp_if_read(ADDR_W'(32'h34), rv_data);
        if_read(ADDR_W'(32'h34), lat_i);
        check("err_sticky", err, 1);
        check("d_rdata_hold", d_rdata, 32'hDEAD_BEEF);

        // Reset during WAIT_R, then a late rvalid.
        rv_en = 1'b0;
        bus_q.push_back({1'b0, 5'b0, 27'h44, 32'h0});
        d_rreq = 1'b1;
        d_addr = ADDR_W'(32'h44);
        repeat (3) @(negedge clk);
        check("pre_rst_state", state_dbg, 2);
        #2;
        rst    = 1'b0;
        d_rreq = 1'b0;
        mdl_if_rdata = '0;
        mdl_d_rdata  = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst1");
        @(posedge clk);
        #2;
        rst      = 1'b1;
        rv_en    = 1'b1;
        rv_data  = 32'h5555_5555;
        force_rv = 1'b1;
        repeat (3) @(negedge clk);
        check("late_rv_d_rdata", d_rdata, 0);
        check("late_rv_state", state_dbg, 0);
        @(posedge clk);
        #1;
        rv_data = 32'hA5A5_5A5A;
        exp_if_read(ADDR_W'(32'h60), rv_data);
        if_read(ADDR_W'(32'h60), lat_i);
        check("post_rst_lat", lat_i, 4);
        check("post_rst_err", err, 0);

        // rreq and wreq together: treated as a write, and err is set.
        exp_d_write(ADDR_W'(32'h70), 32'h7777_7777);
        d_access(1'b1, 1'b1, ADDR_W'(32'h70), 32'h7777_7777, lat_d);
        check("both_lat", lat_d, 3);
        check("both_err", err, 1);

        repeat (4) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("bus_q_empty", bus_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
